// File: rtl/instr_packer.sv
// Instruction packer: encodes register/immediate fields into 32-bit words,
// buffers them in a 4-entry FIFO and streams them into instruction memory.
module instr_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ri,
  input  logic [5:0]  rs,
  input  logic [5:0]  rd,
  input  logic [3:0]  fx,
  input  logic [5:0]  rt,
  input  logic [14:0] imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_stall,
  output logic [8:0]  wr_count,
  output logic        wrapped,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      state;
  logic [31:0] fifo [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [31:0] enc_word;
  logic        push;
  logic        pop;

  always_comb begin
    enc_word = '0;
    if (ri)
      enc_word = {ri, rs, rd, fx, imm};
    else
      enc_word = {ri, rs, rd, fx, rt, 9'd0};
  end

  assign in_ready  = (state == RUN) && (count < 3'd4);
  assign mem_we    = (state != IDLE) && (count != 3'd0) && !mem_stall;
  assign busy      = (state != IDLE);
  assign mem_wdata = fifo[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = mem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_addr <= '0;
      wr_count <= '0;
      wrapped  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= enc_word;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        mem_addr <= mem_addr + 8'd1;
        if (mem_addr == 8'hFF)
          wrapped <= 1'b1;
        if (wr_count != '1)
          wr_count <= wr_count + 9'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // pop cannot coincide with start: the FIFO is always empty in IDLE
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          mem_addr <= base_addr;
          wr_count <= '0;
          wrapped  <= 1'b0;
        end
        RUN:     if (stop) state <= FLUSH;
        FLUSH:   if (count == 3'd0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Randomized and directed bench for instr_packer against a queue-based model.
module tb_instr_packer;

  logic        clk;
  logic        rst, start, stop, in_valid, ri, mem_stall;
  logic [7:0]  base_addr;
  logic [5:0]  rs, rd, rt;
  logic [3:0]  fx;
  logic [14:0] imm;
  logic        in_ready, mem_we, wrapped, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  wr_count;

  int n_chk = 0;
  int n_err = 0;

  // model: 0 = idle, 1 = run, 2 = flush
  int          m_st;
  logic [31:0] q [$];
  int          m_addr, m_cnt;
  bit          m_wrap, m_acc;

  instr_packer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .ri(ri), .rs(rs), .rd(rd),
    .fx(fx), .rt(rt), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_stall(mem_stall), .wr_count(wr_count),
    .wrapped(wrapped), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input bit fri, input int frs, input int frd,
                                         input int ffx, input int frt, input int fimm);
    longint v;
    v = (longint'(fri) << 31) + (longint'(frs) << 25) + (longint'(frd) << 19) + (longint'(ffx) << 15);
    if (fri) v = v + fimm;
    else     v = v + frt * 512;
    return v[31:0];
  endfunction

  task automatic set_fields(input bit fri, input int frs, input int frd,
                            input int ffx, input int frt, input int fimm);
    ri = fri; rs = 6'(frs); rd = 6'(frd); fx = 4'(ffx); rt = 6'(frt); imm = 15'(fimm);
  endtask

  task automatic rand_fields();
    set_fields(1'($urandom), $urandom_range(0, 63), $urandom_range(0, 63),
               $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 32767));
  endtask

  // Compare against the model, advance it across one clock edge, then clear pulses.
  task automatic cycle();
    bit exp_rdy, exp_we;
    int sz0;
    logic [31:0] w;
    #1;
    sz0     = q.size();
    exp_rdy = (m_st == 1) && (sz0 < 4);
    exp_we  = (m_st != 0) && (sz0 > 0) && !mem_stall;
    check("in_ready", in_ready, exp_rdy);
    check("mem_we", mem_we, exp_we);
    check("busy", busy, m_st != 0);
    check("wr_count", wr_count, m_cnt);
    check("wrapped", wrapped, m_wrap);
    check("mem_addr", mem_addr, m_addr);
    if (exp_we) check("mem_wdata", mem_wdata, q[0]);
    m_acc = 0;
    if (rst) begin
      m_st = 0; q.delete(); m_addr = 0; m_cnt = 0; m_wrap = 0;
    end else begin
      w = encode(ri, rs, rd, fx, rt, imm);
      m_acc = in_valid && exp_rdy;
      if (exp_we) begin
        void'(q.pop_front());
        if (m_addr == 255) m_wrap = 1;
        m_addr = (m_addr + 1) % 256;
        if (m_cnt < 511) m_cnt++;
      end
      if (m_acc) q.push_back(w);
      case (m_st)
        0: if (start) begin m_st = 1; m_addr = base_addr; m_cnt = 0; m_wrap = 0; end
        1: if (stop) m_st = 2;
        default: if (sz0 == 0) m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
    start = 0; stop = 0; rst = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; mem_stall = 0;
    cycle();
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (q.size() != 0 || m_st == 2); i++) cycle();
    check("drain_bound", (q.size() == 0 && m_st != 2), 1);
  endtask

  task automatic pulse_start(input logic [7:0] b);
    base_addr = b; start = 1; in_valid = 0;
    cycle();
  endtask

  task automatic stop_to_idle();
    stop = 1; in_valid = 0;
    cycle();
    drain(20);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; in_valid = 0; mem_stall = 0; base_addr = 0;
    set_fields(0, 0, 0, 0, 0, 0);
    m_st = 0; m_addr = 0; m_cnt = 0; m_wrap = 0; m_acc = 0;
    @(posedge clk); #1;
    do_reset();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_busy", busy, 0);

    // register-format encode
    pulse_start(8'h10);
    set_fields(0, 3, 1, 2, 5, 15'h7FFF); in_valid = 1;
    cycle();
    in_valid = 0; #1;
    check("reg_we", mem_we, 1);
    check("reg_addr", mem_addr, 8'h10);
    check("reg_wdata", mem_wdata, 32'h06090A00);
    cycle();
    check("reg_count", wr_count, 1);

    // immediate-format encode
    set_fields(1, 1, 2, 4'hA, 6'h3F, 15'h1234); in_valid = 1;
    cycle();
    in_valid = 0; #1;
    check("imm_wdata", mem_wdata, 32'h82151234);
    check("imm_addr", mem_addr, 8'h11);
    cycle();

    // backpressure: 4 accepted under stall, 5th held off until space frees
    mem_stall = 1;
    for (int i = 0; i < 5; i++) begin
      rand_fields(); in_valid = 1;
      cycle();
      check("bp_accept", m_acc, i < 4);
    end
    mem_stall = 0; #1;
    check("bp_full_ready", in_ready, 0);
    for (int i = 0; i < 10 && in_valid; i++) begin
      cycle();
      if (m_acc) in_valid = 0;
    end
    check("bp_fifth_accepted", in_valid, 0);
    drain(20);
    check("bp_count", wr_count, 7);
    check("bp_addr", mem_addr, 8'h17);
    stop_to_idle();

    // address wrap
    pulse_start(8'hFE);
    for (int i = 0; i < 3; i++) begin
      rand_fields(); in_valid = 1;
      cycle();
    end
    in_valid = 0;
    drain(20);
    check("wrap_flag", wrapped, 1);
    check("wrap_addr", mem_addr, 8'h01);
    stop_to_idle();
    pulse_start(8'h40);
    check("wrap_cleared", wrapped, 0);

    // flush under stall
    mem_stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_fields(); in_valid = 1;
      cycle();
    end
    in_valid = 0; stop = 1;
    cycle();
    check("flush_ready", in_ready, 0);
    check("flush_busy", busy, 1);
    mem_stall = 0;
    drain(20);
    check("flush_writes", wr_count, 2);
    check("flush_idle", busy, 0);

    // reset while 3 words are buffered
    pulse_start(8'h80);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_fields(); in_valid = 1;
      cycle();
    end
    in_valid = 0; rst = 1; start = 1; stop = 1;
    cycle();
    mem_stall = 0; #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", mem_addr, 0);
    for (int i = 0; i < 4; i++) cycle();

    // wr_count saturation
    pulse_start(8'($urandom));
    for (int i = 0; i < 520; i++) begin
      rand_fields(); in_valid = 1;
      cycle();
    end
    in_valid = 0;
    drain(20);
    check("sat_count", wr_count, 511);
    stop_to_idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      base_addr = 8'($urandom);
      in_valid  = 1'($urandom);
      mem_stall = ($urandom_range(0, 3) == 0);
      rand_fields();
      cycle();
    end
    mem_stall = 0; in_valid = 0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_packer.md
INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; in IDLE, loads base_addr and enters RUN.
REQ-005 stop  in  1  one-cycle pulse; in RUN, enters FLUSH.
REQ-006 base_addr  in  8  first instruction-memory word address.
REQ-007 in_valid / in_ready  in / out  1 / 1  field handshake; a transfer occurs when both are high on a clock edge.
REQ-008 ri  in  1  format select: 0 = register, 1 = immediate.
REQ-009 rs, rd  in  6 each  source and destination register.
REQ-010 fx  in  4  ALU function code.
REQ-011 rt  in  6  second source register; used only when ri=0.
REQ-012 imm  in  15  immediate; used only when ri=1.
REQ-013 mem_we  out  1  instruction-memory write strobe.
REQ-014 mem_addr  out  8  write address.
REQ-015 mem_wdata  out  32  encoded instruction word.
REQ-016 mem_stall  in  1  memory cannot accept a write this cycle.
REQ-017 wr_count  out  9  words written since the last start.
REQ-018 wrapped  out  1  sticky flag: mem_addr wrapped from 255 to 0.
REQ-019 busy  out  1  high in RUN or FLUSH.

Function
REQ-020 Encoding SHALL be as follows:
- [31]=ri, [30:25]=rs, [24:19]=rd, [18:15]=fx.
- ri=0: [14:9]=rt and [8:0]=0; imm is ignored.
- ri=1: [14:0]=imm; rt is ignored.
REQ-021 Encoding SHALL occur at acceptance; the encoded word is stored in a 4-entry FIFO.
REQ-022 States SHALL be IDLE, RUN and FLUSH.
- IDLE->RUN on start.
- RUN->FLUSH on stop.
- FLUSH->IDLE when the FIFO is empty and no write is pending.
- start is ignored outside IDLE; stop is ignored outside RUN.
REQ-023 in_ready SHALL equal (state==RUN) AND (FIFO count<4).
- When full, in_ready is low even if a pop occurs in the same cycle.
- in_ready does not depend on in_valid.
REQ-024 mem_we SHALL equal (state is RUN or FLUSH) AND FIFO non-empty AND !mem_stall, combinationally.
- mem_wdata = FIFO head; mem_addr = address register.
REQ-025 On each clock edge with mem_we high, the block SHALL:
- pop the FIFO;
- increment mem_addr modulo 256;
- increment wr_count, saturating at 511.
REQ-026 When mem_addr increments from 255 to 0, wrapped SHALL set and hold until the next start or rst; writing continues.
REQ-027 Latency: a word accepted at edge N SHALL appear on mem_wdata/mem_we no earlier than the cycle after edge N (minimum 1 cycle).
REQ-028 Words SHALL be written in acceptance order with no loss or duplication under any mem_stall pattern.
REQ-029 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-030 mem_wdata, mem_addr and wr_count SHALL hold their values while mem_stall is high.
REQ-031 start in IDLE SHALL load mem_addr=base_addr, clear wr_count and clear wrapped on the same edge.
REQ-032 busy SHALL be high in RUN and FLUSH, low in IDLE.
REQ-033 In IDLE, the FIFO SHALL be empty, in_ready=0 and mem_we=0.

Reset
REQ-034 On a clock edge with rst high, regardless of state, the block SHALL:
- enter IDLE and empty the FIFO;
- set mem_addr=0, wr_count=0, wrapped=0, busy=0, in_ready=0.
REQ-035 mem_we SHALL be 0 in the cycle following reset.
REQ-036 mem_wdata after reset SHALL read 0.
REQ-037 Reset mid-RUN or mid-FLUSH SHALL discard FIFO contents without writing them.
REQ-038 rst SHALL take priority over start and stop asserted in the same cycle.

Verification
REQ-039 Register encode: start with base_addr=0x10; push ri=0, rs=3, rd=1, fx=2, rt=5, imm=0x7FFF -> mem_we with mem_addr=0x10, mem_wdata=0x06090A00; then wr_count=1.
REQ-040 Immediate encode: push ri=1, rs=1, rd=2, fx=0xA, rt=0x3F, imm=0x1234 -> mem_wdata=0x82151234.
REQ-041 Backpressure: hold mem_stall=1, push 5 words -> exactly 4 accepted and in_ready=0; release mem_stall -> 4 consecutive writes at incrementing addresses in order; 5th then accepted and written.
REQ-042 Wrap: base_addr=0xFE, push 3 words -> addresses 0xFE, 0xFF, 0x00; wrapped=1 after the third write; a new start clears wrapped.
REQ-043 Flush: push 2 words under mem_stall, pulse stop -> in_ready=0, busy=1; release stall -> 2 writes, then IDLE and busy=0.
REQ-044 Reset mid-operation: rst while FIFO holds 3 words -> no further mem_we; all outputs at their reset values on the next cycle.
